// File: rtl/add_clip_d8_if.sv
// add_clip_d8_if: tagged FIFO read/write interfaces between actors and their FIFOs
interface read_interface #(parameter int FLUX = 2, parameter int W = 8);
  logic [FLUX-1:0] empty;
  logic [FLUX-1:0][W-1:0] dout;
  logic [FLUX-1:0] read;
  modport master(input empty, input dout, output read);
  modport slave(output empty, output dout, input read);
endinterface

interface write_interface #(parameter int FLUX = 2, parameter int W = 8);
  logic [FLUX-1:0] full;
  logic write;
  logic [W-1:0] din;
  modport master(input full, output write, output din);
  modport slave(output full, input write, input din);
endinterface

// File: rtl/add_clip_d8.sv
// add_clip_d8: round-robin interleaved pred+residual reconstruction with clip to pel range
module add_clip_d8 #(
  parameter int FLUX = 2,
  parameter int PEL_WIDTH = 8,
  parameter int RES_WIDTH = 9
) (
  input logic clk,
  input logic rst,
  read_interface.master read_port_in_pred,
  read_interface.master read_port_in_res,
  write_interface.master write_port_out_pel
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int SUM_WIDTH = (PEL_WIDTH + 1 > RES_WIDTH ? PEL_WIDTH + 1 : RES_WIDTH) + 1;
  logic out_valid, found;
  logic [TAG_WIDTH-1:0] out_tag, rr_ptr, sel;
  logic [PEL_WIDTH-1:0] out_data, clip_pel;
  logic [FLUX-1:0] elig, rd;
  logic signed [SUM_WIDTH-1:0] sum;
  logic unused_bits;
  assign unused_bits = ^{read_port_in_pred.dout, read_port_in_res.dout};
  always_comb begin
    for (int i = 0; i < FLUX; i++)
      elig[i] = !read_port_in_pred.empty[i] && !read_port_in_res.empty[i] &&
                !write_port_out_pel.full[i] && !(out_valid && out_tag == TAG_WIDTH'(i));
    found = 1'b0;
    sel = rr_ptr;
    // walk from farthest to nearest so the flux right after rr_ptr wins
    for (int k = FLUX; k >= 1; k--)
      if (elig[TAG_WIDTH'((int'(rr_ptr) + k) % FLUX)]) begin
        found = 1'b1;
        sel = TAG_WIDTH'((int'(rr_ptr) + k) % FLUX);
      end
    sum = SUM_WIDTH'($signed({1'b0, read_port_in_pred.dout[sel][PEL_WIDTH-1:0]})) +
          SUM_WIDTH'($signed(read_port_in_res.dout[sel][RES_WIDTH-1:0]));
    clip_pel = sum[SUM_WIDTH-1] ? '0 : (|sum[SUM_WIDTH-2:PEL_WIDTH]) ? '1 : sum[PEL_WIDTH-1:0];
    rd = (found && !rst) ? FLUX'(1) << sel : '0;
  end
  assign read_port_in_pred.read = rd;
  assign read_port_in_res.read = rd;
  assign write_port_out_pel.write = out_valid;
  assign write_port_out_pel.din = {out_tag, out_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rr_ptr <= TAG_WIDTH'(FLUX - 1);
    end else begin
      out_valid <= found;
      if (found) begin
        rr_ptr <= sel;
        out_tag <= sel;
        out_data <= clip_pel;
      end
    end
  end
endmodule
